cache_line_mover: RTL and testbench
===================================

Name: cache_line_mover

Overview:
- Memory-side stage directly downstream of the write-back cache.
- On a cache miss it accepts one request: optionally write back a dirty victim block word by word, then refill the new block word by word from main memory.
- Streams fill words back to the cache and owns the memory address, write-data and write-enable pins while busy.

Parameters:
- WORDS_PER_BLOCK, 4, words per cache block; power of two, at least 2.
- MEM_READ_LATENCY, 1, cycles from mem_addr stable to mem_data_out valid; 0 means combinational memory.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  cache presents a miss request.
- req_ready  out  1  block is able to accept a request.
- req_write_back  in  1  victim is dirty; write it back before the fill.
- req_evict_addr  in  32  victim block address; low log2(WORDS_PER_BLOCK*4) bits ignored.
- req_fill_addr  in  32  miss address; block bits select the block, word bits are used only with the optional feature.
- evict_word_idx  out  log2(WORDS_PER_BLOCK)  word index of the victim requested from the cache.
- evict_data  in  8x[0:3]  victim word at evict_word_idx, supplied combinationally by the cache.
- fill_valid  out  1  fill_data and fill_word_idx are valid this cycle.
- fill_word_idx  out  log2(WORDS_PER_BLOCK)  index of the word being filled.
- fill_data  out  8x[0:3]  word read from memory.
- done  out  1  one-cycle pulse when the request completes.
- mem_addr  out  32  word address driven to memory.
- mem_data_in  out  8x[0:3]  write data driven to memory.
- mem_write_en  out  1  memory write strobe.
- mem_data_out  in  8x[0:3]  memory read data.

Behaviour:
- Reset (asynchronous, reset low): state IDLE, word counter 0, wait counter 0.
- Outputs during reset: req_ready=1, fill_valid=0, done=0, mem_write_en=0, mem_addr=0, evict_word_idx=0.
- Reset asserted mid-request aborts immediately. mem_write_en drops asynchronously. A partial write-back is not resumed.

States and transitions:
- IDLE: req_ready=1. On the cycle req_valid&&req_ready, latch both block addresses and req_write_back.
  - If req_write_back=1, go to EVICT; otherwise go to FILL.
  - req_ready=0 in every state other than IDLE.
- EVICT: one word per cycle, WORDS_PER_BLOCK cycles in total.
  - evict_word_idx=k, mem_addr=evict_base+4k, mem_data_in=evict_data, mem_write_en=1.
  - After k=WORDS_PER_BLOCK-1, go to FILL with k reset to 0.
- FILL: for each word k, mem_addr=fill_base+4*idx is held stable for MEM_READ_LATENCY+1 cycles, with mem_write_en=0.
  - On the last of those cycles: fill_valid=1, fill_word_idx=idx, fill_data=mem_data_out, passed through combinationally.
  - After the last word, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. req_ready stays 0 in DONE, so back-to-back requests have a one-cycle gap.

Timing and data rules:
- Total latency from accept to done pulse: (req_write_back ? WORDS_PER_BLOCK : 0) + WORDS_PER_BLOCK*(MEM_READ_LATENCY+1) + 1 cycles.
- Index arithmetic is modulo WORDS_PER_BLOCK (wraps naturally). Address adds never carry out of the block.
- fill_valid and mem_write_en are never high in the same cycle.
- req_valid asserted while busy is ignored. The cache must hold the request until req_ready.
- Inputs req_* are sampled only on the accept edge; later changes have no effect.

Optional Feature:
- Macro: CACHE_CRITICAL_WORD_FIRST_EN.
- Defined: the fill starts at word w0=req_fill_addr[log2(WORDS_PER_BLOCK*4)-1:2], then proceeds w0+1 and so on, wrapping modulo WORDS_PER_BLOCK. The first fill_valid therefore carries the missed word.
- Undefined: the fill always runs from word 0 upward and the word bits of req_fill_addr are ignored.
- Cycle counts are identical with and without the macro.

Decomposition:
- Shared package cache_pkg holds:
  - typedef for the byte-array word (8x[0:3]);
  - the state enum (IDLE, EVICT, FILL, DONE);
  - constant BYTE_OFFSET_BITS=2;
  - function block_align(addr, words).
- No sub-module: one FSM with a word counter and a latency wait counter, in a single module.

Test Plan:
- Clean miss, req_fill_addr=0x0000_0108, req_write_back=0, LAT=1 -> mem_addr 0x100,0x100,0x104,0x104,0x108,0x108,0x10C,0x10C. fill_valid on cycles 2,4,6,8 with idx 0..3. done at cycle 9.
- Dirty miss, evict_addr=0x0000_0230, fill_addr=0x40, LAT=0 -> 4 write cycles: mem_write_en=1, addr 0x230..0x23C, mem_data_in=evict_data per idx. Then 4 fill cycles at 0x40..0x4C. done 9 cycles after accept.
- CACHE_CRITICAL_WORD_FIRST_EN defined, fill_addr=0x0000_0038, LAT=0 -> fill_word_idx order 2,3,0,1; mem_addr order 0x38,0x3C,0x30,0x34.
- reset pulled low during the third EVICT cycle -> mem_write_en=0 in the same cycle, req_ready=1, no fill_valid or done. A new request after release completes normally.
- req_valid held high continuously with two distinct requests -> second accepted only in the IDLE cycle after the done pulse. req_ready=0 throughout the busy and DONE states.
- req_fill_addr changed during FILL -> fill addresses unchanged from the latched base.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and helpers for the memory-side cache line mover.
//   word_t          : one 32-bit memory word held as four bytes, byte 0 first
//   state_t         : mover FSM states (IDLE, EVICT, FILL, DONE)
//   BYTE_OFFSET_BITS: address bits that select a byte inside a word
//   block_align()   : clears the in-block offset bits of a byte address
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int BYTE_OFFSET_BITS = 2;

    typedef logic [0:3][7:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVICT = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 'words' is a power of two, so the block size in bytes minus one is a
    // mask of exactly the offset bits.
    function automatic logic [31:0] block_align(input logic [31:0] addr,
                                                input int unsigned words);
        logic [31:0] offset_mask;
        offset_mask = (32'(words) << BYTE_OFFSET_BITS) - 32'd1;
        return addr & ~offset_mask;
    endfunction

endpackage

// File: rtl/cache_line_mover.sv
// -----------------------------------------------------------------------------
// cache_line_mover
// Memory-side stage behind the write-back cache. Accepts one miss request,
// optionally writes the dirty victim block back one word per cycle, then
// refills the missed block one word at a time, streaming each fill word back
// to the cache, and finishes with a one-cycle done pulse.
//
// Parameters
//   WORDS_PER_BLOCK  : words per block (power of two, >= 2)
//   MEM_READ_LATENCY : cycles from mem_addr stable to mem_data_out valid
//                      (0 = combinational memory)
//
// Ports
//   clk, reset               : clock, asynchronous active-low reset
//   req_valid / req_ready    : miss request handshake
//   req_write_back           : victim is dirty, write it back first
//   req_evict_addr           : victim block address
//   req_fill_addr            : missed address
//   evict_word_idx/evict_data: victim word request / combinational reply
//   fill_valid, fill_word_idx, fill_data : fill word stream to the cache
//   done                     : request complete pulse
//   mem_addr, mem_data_in, mem_write_en, mem_data_out : memory pins
//
// Configuration macro
//   CACHE_CRITICAL_WORD_FIRST_EN : when defined, the fill starts at the missed
//   word and wraps around the block; otherwise it always starts at word 0.
//   Cycle counts are identical either way.
// -----------------------------------------------------------------------------
module cache_line_mover
    import cache_pkg::*;
#(
    parameter int WORDS_PER_BLOCK  = 4,
    parameter int MEM_READ_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write_back,
    input  logic [31:0]                        req_evict_addr,
    input  logic [31:0]                        req_fill_addr,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] evict_word_idx,
    input  word_t                              evict_data,
    output logic                               fill_valid,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
    output word_t                              fill_data,
    output logic                               done,
    output logic [31:0]                        mem_addr,
    output word_t                              mem_data_in,
    output logic                               mem_write_en,
    input  word_t                              mem_data_out
);

    localparam int IW = $clog2(WORDS_PER_BLOCK);
    localparam int WW = (MEM_READ_LATENCY > 0) ? $clog2(MEM_READ_LATENCY + 1) : 1;
    localparam logic [IW-1:0] LAST_WORD = IW'(WORDS_PER_BLOCK - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(MEM_READ_LATENCY);

    state_t          r_state;
    logic [IW-1:0]   r_word_cnt;
    logic [WW-1:0]   r_wait_cnt;
    logic            r_write_back;
    logic [31:0]     r_evict_addr;
    logic [31:0]     r_fill_addr;

    logic [IW-1:0]   w_fill_start;
    logic [IW-1:0]   w_fill_idx;
    logic [31:0]     w_evict_base;
    logic [31:0]     w_fill_base;
    logic            w_fill_last_wait;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    // Missed word comes out first; the word counter is added to it and wraps.
    assign w_fill_start = r_fill_addr[BYTE_OFFSET_BITS +: IW];
`else
    assign w_fill_start = '0;
`endif

    assign w_fill_idx       = r_word_cnt + w_fill_start;
    assign w_evict_base     = block_align(r_evict_addr, WORDS_PER_BLOCK);
    assign w_fill_base      = block_align(r_fill_addr, WORDS_PER_BLOCK);
    assign w_fill_last_wait = (r_wait_cnt == LAST_WAIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_word_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_write_back <= 1'b0;
            r_evict_addr <= '0;
            r_fill_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        // Request fields are captured only here; the cache may
                        // change them freely once the request is accepted.
                        r_write_back <= req_write_back;
                        r_evict_addr <= req_evict_addr;
                        r_fill_addr  <= req_fill_addr;
                        r_word_cnt   <= '0;
                        r_wait_cnt   <= '0;
                        r_state      <= req_write_back ? EVICT : FILL;
                    end
                end
                EVICT: begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    if (r_word_cnt == LAST_WORD) begin
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (w_fill_last_wait) begin
                        r_wait_cnt <= '0;
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (r_word_cnt == LAST_WORD) begin
                            r_state <= DONE;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state only (plus the two data
    // pass-throughs), so reset forces them to their idle values immediately.
    // NOTE: every output gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        req_ready      = 1'b0;
        evict_word_idx = '0;
        fill_valid     = 1'b0;
        fill_word_idx  = '0;
        fill_data      = mem_data_out;
        done           = 1'b0;
        mem_addr       = '0;
        mem_data_in    = '0;
        mem_write_en   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
            end
            EVICT: begin
                evict_word_idx = r_word_cnt;
                // OR instead of add: the offset never carries out of the block.
                mem_addr       = w_evict_base | (32'(r_word_cnt) << BYTE_OFFSET_BITS);
                mem_data_in    = evict_data;
                mem_write_en   = 1'b1;
            end
            FILL: begin
                mem_addr      = w_fill_base | (32'(w_fill_idx) << BYTE_OFFSET_BITS);
                fill_valid    = w_fill_last_wait;
                fill_word_idx = w_fill_idx;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_mover.sv
// -----------------------------------------------------------------------------
// tb_cache_line_mover
// Self-checking bench for cache_line_mover (WORDS_PER_BLOCK=4,
// MEM_READ_LATENCY=1). A transaction-level model derives the expected pins of
// every cycle of a request from its position in the request timeline.
// -----------------------------------------------------------------------------
module tb_cache_line_mover;
    import cache_pkg::*;

    localparam int W   = 4;
    localparam int LAT = 1;
    localparam int IW  = $clog2(W);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write_back = 1'b0;
    logic [31:0]   req_evict_addr = '0;
    logic [31:0]   req_fill_addr = '0;
    logic [IW-1:0] evict_word_idx;
    word_t         evict_data;
    logic          fill_valid;
    logic [IW-1:0] fill_word_idx;
    word_t         fill_data;
    logic          done;
    logic [31:0]   mem_addr;
    word_t         mem_data_in;
    logic          mem_write_en;
    word_t         mem_data_out;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   salt = 32'h1234_5678;

    // Values presented on the request pins while busy in the back-to-back test.
    logic          nx_wb = 1'b0;
    logic [31:0]   nx_ev = '0;
    logic [31:0]   nx_fa = '0;

    cache_line_mover #(
        .WORDS_PER_BLOCK (W),
        .MEM_READ_LATENCY(LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write_back(req_write_back),
        .req_evict_addr(req_evict_addr),
        .req_fill_addr (req_fill_addr),
        .evict_word_idx(evict_word_idx),
        .evict_data    (evict_data),
        .fill_valid    (fill_valid),
        .fill_word_idx (fill_word_idx),
        .fill_data     (fill_data),
        .done          (done),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .mem_write_en  (mem_write_en),
        .mem_data_out  (mem_data_out)
    );

    always #5 clk = ~clk;

    function automatic word_t mem_word(input logic [31:0] a);
        return word_t'((a * 32'h9E37_79B1) ^ 32'h5A5A_1234);
    endfunction

    function automatic word_t ev_word(input logic [31:0] s, input int idx);
        return word_t'(s ^ (32'(idx) * 32'h0101_0101 + 32'h0000_0011));
    endfunction

    // Memory and cache replies are pure functions of what the DUT asks for.
    assign mem_data_out = mem_word(mem_addr);
    assign evict_data   = ev_word(salt, int'(evict_word_idx));

    // Runs one request from an IDLE negedge. abort_at>0 returns right after
    // checking that cycle; hold keeps req_valid high with nx_* while busy.
    task automatic run_req(input logic wb, input logic [31:0] ev, input logic [31:0] fa,
                           input int abort_at, input logic hold);
        int          total, start, f, word, idx, k;
        logic        e_we, e_fv, e_done, chk_addr;
        logic [31:0] e_addr, mask;
        word_t       e_wdata, e_fdata;
        int          e_eidx, e_fidx;
        mask  = 32'(W * 4 - 1);
        start = CWF ? int'((fa >> 2) % W) : 0;
        total = (wb ? W : 0) + W * (LAT + 1) + 1;
        req_write_back = wb;
        req_evict_addr = ev;
        req_fill_addr  = fa;
        req_valid      = 1'b1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_ready: got %b want 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        for (int t = 1; t <= total; t++) begin
            e_we = 1'b0; e_fv = 1'b0; e_done = (t == total); chk_addr = 1'b0;
            e_addr = '0; e_wdata = '0; e_fdata = '0; e_eidx = 0; e_fidx = 0;
            if (wb && t <= W) begin
                k        = t - 1;
                e_we     = 1'b1;
                chk_addr = 1'b1;
                e_addr   = (ev & ~mask) + 32'(4 * k);
                e_wdata  = ev_word(salt, k);
                e_eidx   = k;
            end else if (t < total) begin
                f        = t - 1 - (wb ? W : 0);
                word     = f / (LAT + 1);
                idx      = (start + word) % W;
                chk_addr = 1'b1;
                e_addr   = (fa & ~mask) + 32'(4 * idx);
                e_fv     = ((f % (LAT + 1)) == LAT);
                e_fidx   = idx;
                e_fdata  = mem_word(e_addr);
            end
            n_checks++;
            if ({mem_write_en, fill_valid, done, req_ready} !== {e_we, e_fv, e_done, 1'b0}) begin
                n_errors++;
                $display("FAIL ctrl t=%0d: got we/fv/done/rdy=%b%b%b%b want %b%b%b0",
                         t, mem_write_en, fill_valid, done, req_ready, e_we, e_fv, e_done);
            end
            if (chk_addr) begin
                n_checks++;
                if (mem_addr !== e_addr) begin
                    n_errors++;
                    $display("FAIL mem_addr t=%0d: got %h want %h", t, mem_addr, e_addr);
                end
            end
            if (e_we) begin
                n_checks++;
                if (mem_data_in !== e_wdata || int'(evict_word_idx) != e_eidx) begin
                    n_errors++;
                    $display("FAIL evict t=%0d: got idx %0d data %h want idx %0d data %h",
                             t, evict_word_idx, mem_data_in, e_eidx, e_wdata);
                end
            end
            if (e_fv) begin
                n_checks++;
                if (fill_data !== e_fdata || int'(fill_word_idx) != e_fidx) begin
                    n_errors++;
                    $display("FAIL fill t=%0d: got idx %0d data %h want idx %0d data %h",
                             t, fill_word_idx, fill_data, e_fidx, e_fdata);
                end
            end
            if (t == abort_at) return;
            if (hold) begin
                req_valid      = 1'b1;
                req_write_back = nx_wb;
                req_evict_addr = nx_ev;
                req_fill_addr  = nx_fa;
            end else begin
                // Busy-time request pin activity must have no effect.
                req_valid      = 1'($urandom_range(0, 1));
                req_write_back = 1'($urandom_range(0, 1));
                req_evict_addr = $urandom;
                req_fill_addr  = $urandom;
            end
            @(negedge clk);
        end
        n_checks++;
        if ({req_ready, fill_valid, done, mem_write_en} !== 4'b1000) begin
            n_errors++;
            $display("FAIL idle_after: got rdy/fv/done/we=%b%b%b%b want 1000",
                     req_ready, fill_valid, done, mem_write_en);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({req_ready, fill_valid, done, mem_write_en} !== 4'b1000 ||
            mem_addr !== 32'h0 || evict_word_idx !== '0) begin
            n_errors++;
            $display("FAIL reset: got rdy/fv/done/we=%b%b%b%b addr %h eidx %0d want 1000 0 0",
                     req_ready, fill_valid, done, mem_write_en, mem_addr, evict_word_idx);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_miss();
        salt = $urandom;
        run_req(1'b0, 32'h0, 32'h0000_0108, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_dirty_miss();
        salt = $urandom;
        run_req(1'b1, 32'h0000_0230, 32'h0000_0040, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_critical_word();
        salt = $urandom;
        run_req(1'b0, 32'h0, 32'h0000_0038, 0, 1'b0);
        run_req(1'b1, 32'h0000_0FFC, 32'hFFFF_FFFC, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            salt = $urandom;
            run_req(1'($urandom_range(0, 1)), $urandom, $urandom, 0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_evict();
        salt = $urandom;
        run_req(1'b1, 32'h0000_0500, 32'h0000_0700, 3, 1'b0);
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        n_checks++;
        if ({mem_write_en, req_ready, fill_valid, done} !== 4'b0100) begin
            n_errors++;
            $display("FAIL abort_now: got we/rdy/fv/done=%b%b%b%b want 0100",
                     mem_write_en, req_ready, fill_valid, done);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_write_en, req_ready, fill_valid, done} !== 4'b0100) begin
                n_errors++;
                $display("FAIL abort_hold %0d: got we/rdy/fv/done=%b%b%b%b want 0100",
                         i, mem_write_en, req_ready, fill_valid, done);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        salt = $urandom;
        run_req(1'b1, 32'h0000_0600, 32'h0000_0804, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        nx_wb = 1'b1;
        nx_ev = 32'h0000_0A10;
        nx_fa = 32'h0000_0B2C;
        salt  = $urandom;
        run_req(1'b0, 32'h0, 32'h0000_0C00, 0, 1'b1);
        run_req(nx_wb, nx_ev, nx_fa, 0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_critical_word();
        test_reset_mid_evict();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
